// File: rtl/ms_pkg.sv
// Shared types and constants for the MS maze-solver job scheduler.
package ms_pkg;

  localparam int MS_MAZE_BITS = 225;
  localparam int MS_COORD_W   = 4;
  localparam int BIT_CNT_W    = 8;

  typedef logic [MS_COORD_W-1:0] coord_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT,
    DRAIN,
    DONE,
    ABORT,
    COOL
  } state_t;

endpackage

// File: rtl/ms_rr_arb.sv
// Round-robin arbiter: first set request at or above rr_ptr, wrapping modulo N_REQ.
module ms_rr_arb #(
  parameter int N_REQ = 2,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    rr_ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IW-1:0]    gnt_idx,
  output logic             any
);

  logic [IW-1:0] k;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    k       = rr_ptr;
    for (int i = 0; i < N_REQ; i++) begin
      if (!any && req[k]) begin
        any     = 1'b1;
        gnt[k]  = 1'b1;
        gnt_idx = k;
      end
      k = (k == IW'(N_REQ - 1)) ? '0 : k + 1'b1;
    end
  end

endmodule

// File: rtl/ms_job_sched.sv
// Shares one MS maze solver between N_REQ sources: arbitrates, streams the maze in,
// returns the tagged result burst and recovers the solver via a watchdog.
//
// state | meaning
// IDLE  | no job; arbitrate pending requests
// LOAD  | stream granted source's maze bits to the solver
// WAIT  | maze loaded; waiting for first result beat (watchdog running)
// DRAIN | forwarding result beats (watchdog restarted)
// DONE  | one-cycle job_done pulse, advance round-robin pointer
// ABORT | one-cycle job_abort and solver reset pulse, advance pointer
// COOL  | COOL_CYC idle cycles so the solver settles back to its idle state
module ms_job_sched
  import ms_pkg::*;
#(
  parameter int N_REQ     = 2,
  parameter int MAZE_BITS = MS_MAZE_BITS,
  parameter int TIMEOUT   = 1023,
  parameter int COOL_CYC  = 2,
  localparam int ID_W     = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  input  logic [N_REQ-1:0] src_valid,
  input  logic [N_REQ-1:0] src_bit,
  output logic             ms_in_valid,
  output logic             ms_maze,
  output logic             ms_srst_n,
  input  logic             ms_out_valid,
  input  logic             ms_not_valid,
  input  coord_t           ms_out_x,
  input  coord_t           ms_out_y,
  output logic             res_valid,
  output logic [ID_W-1:0]  res_id,
  output coord_t           res_x,
  output coord_t           res_y,
  output logic             res_fail,
  output logic             job_done,
  output logic             job_abort,
  output logic             busy
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam int CW   = $clog2(COOL_CYC + 1);

  state_t                 state_q, state_d;
  logic [N_REQ-1:0]       grant_q;
  logic [ID_W-1:0]        g_q;
  logic [ID_W-1:0]        rr_ptr_q;
  logic [ID_W-1:0]        next_ptr;
  logic [BIT_CNT_W-1:0]   bit_cnt_q;
  logic [WD_W-1:0]        wd_cnt_q;
  logic [CW-1:0]          cool_cnt_q;
  logic [N_REQ-1:0]       arb_gnt;
  logic [ID_W-1:0]        arb_idx;
  logic                   arb_any;
  logic                   bit_last;
  logic                   wd_expired;
  logic                   capture;

  ms_rr_arb #(
    .N_REQ (N_REQ),
    .IW    (ID_W)
  ) u_arb (
    .req     (req),
    .rr_ptr  (rr_ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any     (arb_any)
  );

  assign grant      = grant_q;
  assign busy       = (state_q != IDLE);
  assign bit_last   = (bit_cnt_q == BIT_CNT_W'(MAZE_BITS - 1));
  assign wd_expired = (wd_cnt_q == WD_W'(TIMEOUT));
  assign next_ptr   = (g_q == ID_W'(N_REQ - 1)) ? '0 : g_q + 1'b1;

  // A beat sampled on the cycle the DRAIN watchdog fires is dropped: ABORT carries no result.
  assign capture = ms_out_valid &&
                   ((state_q == WAIT) || ((state_q == DRAIN) && !wd_expired));

  always_comb begin
    state_d     = state_q;
    ms_in_valid = 1'b0;
    ms_maze     = 1'b0;
    ms_srst_n   = 1'b1;
    job_done    = 1'b0;
    job_abort   = 1'b0;
    case (state_q)
      IDLE: if (arb_any) state_d = LOAD;
      LOAD: begin
        ms_in_valid = |(src_valid & grant_q);
        ms_maze     = |(src_bit & grant_q);
        if (ms_in_valid && bit_last) state_d = WAIT;
      end
      WAIT: begin
        if (ms_out_valid)    state_d = DRAIN;
        else if (wd_expired) state_d = ABORT;
      end
      DRAIN: begin
        if (!ms_out_valid)   state_d = DONE;
        else if (wd_expired) state_d = ABORT;
      end
      DONE: begin
        job_done = 1'b1;
        state_d  = COOL;
      end
      ABORT: begin
        job_abort = 1'b1;
        ms_srst_n = 1'b0;
        state_d   = COOL;
      end
      COOL: if (cool_cnt_q == CW'(COOL_CYC - 1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      g_q        <= '0;
      rr_ptr_q   <= '0;
      bit_cnt_q  <= '0;
      wd_cnt_q   <= '0;
      cool_cnt_q <= '0;
      res_valid  <= 1'b0;
      res_id     <= '0;
      res_x      <= '0;
      res_y      <= '0;
      res_fail   <= 1'b0;
    end else begin
      state_q <= state_d;

      if (state_q == IDLE && arb_any) begin
        grant_q <= arb_gnt;
        g_q     <= arb_idx;
      end else if (state_q == DONE || state_q == ABORT) begin
        grant_q  <= '0;
        rr_ptr_q <= next_ptr;
      end

      if (ms_in_valid) bit_cnt_q <= bit_last ? '0 : bit_cnt_q + 1'b1;

      // Watchdog restarts on every state change, so DRAIN entry starts a fresh window.
      if ((state_q == WAIT || state_q == DRAIN) && state_d == state_q)
        wd_cnt_q <= wd_cnt_q + 1'b1;
      else
        wd_cnt_q <= '0;

      cool_cnt_q <= (state_q == COOL && state_d == COOL) ? cool_cnt_q + 1'b1 : '0;

      res_valid <= capture;
      res_id    <= capture ? g_q          : '0;
      res_x     <= capture ? ms_out_x     : '0;
      res_y     <= capture ? ms_out_y     : '0;
      res_fail  <= capture ? ms_not_valid : 1'b0;
    end
  end

endmodule
